mat_nxn_seq_multiplier: RTL

//   Sequential NxN unsigned matrix multiplier C = A x B with valid/ready handshakes on input and output.
//   It is the parametrised successor of the combinational 4x4 multiplier: one time-shared MAC replaces
//   the replicated array, trading latency (N^3 cycles) for area.
//   It sits between an operand-matrix producer and a result consumer; one matrix pair is in flight at a time.

---
 rtl/mat_nxn_seq_multiplier_if.sv | 27 ++
 rtl/mat_nxn_seq_multiplier.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mat_nxn_seq_multiplier_if.sv
// Handshake and matrix bus of the sequential NxN multiplier.
// The producer/consumer side uses the master modport; the multiplier uses slave.
interface mat_nxn_seq_multiplier_if #(
    parameter int N     = 4,
    parameter int DW    = 4,
    parameter int OUT_W = 2 * DW
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N*N*DW-1:0]      a_mat;
    logic [N*N*DW-1:0]      b_mat;
    logic                   out_valid;
    logic                   out_ready;
    logic [N*N*OUT_W-1:0]   c_mat;
    logic                   ovf;
    logic                   busy;

    modport master (
        output in_valid, a_mat, b_mat, out_ready,
        input  in_ready, out_valid, c_mat, ovf, busy
    );

    modport slave (
        input  in_valid, a_mat, b_mat, out_ready,
        output in_ready, out_valid, c_mat, ovf, busy
    );
endinterface

// File: rtl/mat_nxn_seq_multiplier.sv
// Sequential NxN unsigned matrix multiplier, one time-shared MAC, N^3 cycles per product.
// Define MAT_SAT_EN for saturating write-back; otherwise results wrap to OUT_W bits.
module mat_nxn_seq_multiplier #(
    parameter int N     = 4,
    parameter int DW    = 4,
    parameter int OUT_W = 2 * DW
) (
    input  logic clk,
    input  logic rst_n,
    mat_nxn_seq_multiplier_if.slave bus
);
    localparam int IW    = $clog2(N);
    localparam int EW    = $clog2(N * N);
    localparam int ACC_W = 2 * DW + $clog2(N);
    localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_init;
    logic [N*N*DW-1:0]   r_a;
    logic [N*N*DW-1:0]   r_b;
    logic [IW-1:0]       r_i;
    logic [IW-1:0]       r_j;
    logic [IW-1:0]       r_k;
    logic [ACC_W-1:0]    r_acc;
    logic                r_ovf;

    logic [DW-1:0]       w_a_el [N*N];
    logic [DW-1:0]       w_b_el [N*N];
    logic [EW-1:0]       w_a_idx;
    logic [EW-1:0]       w_b_idx;
    logic [EW-1:0]       w_c_idx;
    logic [2*DW-1:0]     w_prod;
    logic [ACC_W-1:0]    w_sum;
    logic [CMP_W-1:0]    w_sum_ext;
    logic                w_elem_ovf;
    logic [OUT_W-1:0]    w_wb_val;
    logic                w_wb_en;
    logic                w_accept;
    logic                w_in_ready;
    logic                w_k_last;
    logic                w_j_last;
    logic                w_i_last;

    // r_init keeps in_ready low until the first clock after reset release
    assign w_in_ready    = (r_state == S_IDLE) && r_init;
    assign w_accept      = w_in_ready && bus.in_valid;
    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = (r_state == S_COMPUTE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.ovf       = r_ovf;

    assign w_k_last = (r_k == LAST);
    assign w_j_last = (r_j == LAST);
    assign w_i_last = (r_i == LAST);

    assign w_a_idx = EW'(r_i) * EW'(N) + EW'(r_k);
    assign w_b_idx = EW'(r_k) * EW'(N) + EW'(r_j);
    assign w_c_idx = EW'(r_i) * EW'(N) + EW'(r_j);

    assign w_prod     = w_a_el[w_a_idx] * w_b_el[w_b_idx];
    assign w_sum      = r_acc + ACC_W'(w_prod);
    assign w_sum_ext  = CMP_W'(w_sum);
    assign w_elem_ovf = |w_sum_ext[CMP_W-1:OUT_W];
    assign w_wb_en    = (r_state == S_COMPUTE) && w_k_last;

`ifdef MAT_SAT_EN
    assign w_wb_val = w_elem_ovf ? {OUT_W{1'b1}} : w_sum_ext[OUT_W-1:0];
`else
    assign w_wb_val = w_sum_ext[OUT_W-1:0];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N * N; gi++) begin : g_elem
            logic [OUT_W-1:0] r_c;

            assign w_a_el[gi] = r_a[gi*DW +: DW];
            assign w_b_el[gi] = r_b[gi*DW +: DW];
            assign bus.c_mat[gi*OUT_W +: OUT_W] = r_c;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_c <= '0;
                else if (w_wb_en && (w_c_idx == EW'(gi)))
                    r_c <= w_wb_val;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_next = S_COMPUTE;
            S_COMPUTE: if (w_k_last && w_j_last && w_i_last) w_state_next = S_DONE;
            S_DONE:    if (bus.out_ready) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_k    <= '0;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_init <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= bus.a_mat;
                        r_b   <= bus.b_mat;
                        r_i   <= '0;
                        r_j   <= '0;
                        r_k   <= '0;
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                S_COMPUTE: begin
                    if (!w_k_last) begin
                        r_acc <= w_sum;
                        r_k   <= r_k + IW'(1);
                    end else begin
                        r_acc <= '0;
                        r_k   <= '0;
                        r_ovf <= r_ovf | w_elem_ovf;
                        if (w_j_last) begin
                            r_j <= '0;
                            r_i <= w_i_last ? '0 : r_i + IW'(1);
                        end else begin
                            r_j <= r_j + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
